// File: rtl/riscv_mbist_pkg.sv
// Shared types for the register-file March C- BIST engine: FSM states,
// data backgrounds and the March element table.
package riscv_mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        BG_SOLID   = 1'b0,
        BG_CHECKER = 1'b1
    } bg_e;

    // One March element: sweep direction, number of ops per address,
    // whether a single-op element reads, and the data polarity of the
    // read (expected) and write ops.
    typedef struct packed {
        logic down;
        logic two_op;
        logic first_rd;
        logic rd_pol;
        logic wr_pol;
    } elem_t;

    localparam logic [2:0] ELEM_LAST = 3'd5;

    // March C-: up(w0) up(r0,w1) up(r1,w0) dn(r0,w1) dn(r1,w0) up(r0)
    function automatic elem_t elem_info(input logic [2:0] elem);
        elem_t e;
        case (elem)
            3'd0:    e = '{down: 1'b0, two_op: 1'b0, first_rd: 1'b0, rd_pol: 1'b0, wr_pol: 1'b0};
            3'd1:    e = '{down: 1'b0, two_op: 1'b1, first_rd: 1'b1, rd_pol: 1'b0, wr_pol: 1'b1};
            3'd2:    e = '{down: 1'b0, two_op: 1'b1, first_rd: 1'b1, rd_pol: 1'b1, wr_pol: 1'b0};
            3'd3:    e = '{down: 1'b1, two_op: 1'b1, first_rd: 1'b1, rd_pol: 1'b0, wr_pol: 1'b1};
            3'd4:    e = '{down: 1'b1, two_op: 1'b1, first_rd: 1'b1, rd_pol: 1'b1, wr_pol: 1'b0};
            3'd5:    e = '{down: 1'b0, two_op: 1'b0, first_rd: 1'b1, rd_pol: 1'b0, wr_pol: 1'b0};
            default: e = '{down: 1'b0, two_op: 1'b0, first_rd: 1'b0, rd_pol: 1'b0, wr_pol: 1'b0};
        endcase
        return e;
    endfunction

    function automatic logic elem_is_down(input logic [2:0] elem);
        elem_t e;
        e = elem_info(elem);
        return e.down;
    endfunction

endpackage

// File: rtl/riscv_mbist_addr_gen.sv
// Loadable up/down address counter spanning [FIRST, LAST]. last_o flags the
// final address of the sweep in the currently selected direction.
module riscv_mbist_addr_gen #(
    parameter int          ADDR_WIDTH = 5,
    parameter int unsigned FIRST      = 1,
    parameter int unsigned LAST       = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  load_top_i,
    input  logic                  step_i,
    input  logic                  down_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    localparam logic [ADDR_WIDTH-1:0] FIRST_A = ADDR_WIDTH'(FIRST);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(LAST);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] addr_r;

    // Address register: load wins over step; direction picks +1 or -1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r <= FIRST_A;
        end else if (load_i) begin
            addr_r <= load_top_i ? LAST_A : FIRST_A;
        end else if (step_i) begin
            addr_r <= down_i ? (addr_r - ONE_A) : (addr_r + ONE_A);
        end else begin
            addr_r <= addr_r;
        end
    end

    assign addr_o = addr_r;
    assign last_o = down_i ? (addr_r == FIRST_A) : (addr_r == LAST_A);

endmodule

// File: rtl/riscv_register_file_mbist.sv
// March C- BIST engine and port multiplexer in front of the register file.
// While running it owns write/read port A and masks write port B; when idle
// every register-file port is a combinational pass-through.
module riscv_register_file_mbist
    import riscv_mbist_pkg::*;
#(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int SKIP_ADDR0   = 1,
    parameter int CHECKERBOARD = 1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] waddr_a_i,
    input  logic [DATA_WIDTH-1:0] wdata_a_i,
    input  logic                  we_a_i,
    input  logic [ADDR_WIDTH-1:0] waddr_b_i,
    input  logic [DATA_WIDTH-1:0] wdata_b_i,
    input  logic                  we_b_i,
    output logic [ADDR_WIDTH-1:0] rf_raddr_a_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_a_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_a_o,
    output logic                  rf_we_a_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_b_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_b_o,
    output logic                  rf_we_b_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
    output logic                  bist_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o,
    output logic [CNT_WIDTH-1:0]  fail_cnt_o
);

    localparam int unsigned FIRST = (SKIP_ADDR0 != 0) ? 1 : 0;
    localparam int unsigned LAST  = (1 << ADDR_WIDTH) - 1;
    localparam logic        CB_EN = (CHECKERBOARD != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Background word: solid zeros, or 0101.. at even / 1010.. at odd
    // addresses; pol=1 selects the inverted ("1") pattern.
    function automatic logic [DATA_WIDTH-1:0] bg_word(input bg_e bg, input logic odd,
                                                      input logic pol);
        logic [DATA_WIDTH-1:0] w;
        if (bg == BG_CHECKER) begin
            w = {(DATA_WIDTH/2){2'b01}} ^ {DATA_WIDTH{odd}};
        end else begin
            w = {DATA_WIDTH{1'b0}};
        end
        return w ^ {DATA_WIDTH{pol}};
    endfunction

    state_e                state_r;
    logic                  bist_r;
    logic                  done_r;
    logic                  pass_r;
    logic [ADDR_WIDTH-1:0] fail_addr_r;
    logic [2:0]            fail_elem_r;
    logic [CNT_WIDTH-1:0]  fail_cnt_r;
    logic [2:0]            elem_r;
    logic                  op_r;
    bg_e                   bg_r;

    elem_t                 info_s;
    logic                  run_s;
    logic                  is_read_s;
    logic                  mismatch_s;
    logic [CNT_WIDTH-1:0]  cnt_next_s;
    logic                  addr_done_s;
    logic                  elem_done_s;
    logic                  test_end_s;
    logic [2:0]            next_elem_s;
    logic                  start_go_s;
    logic                  load_s;
    logic                  load_top_s;
    logic                  step_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic                  last_s;
    logic [DATA_WIDTH-1:0] exp_data_s;
    logic [DATA_WIDTH-1:0] wr_data_s;

    riscv_mbist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .FIRST      (FIRST),
        .LAST       (LAST)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_s),
        .load_top_i (load_top_s),
        .step_i     (step_s),
        .down_i     (info_s.down),
        .addr_o     (addr_s),
        .last_o     (last_s)
    );

    // Op decode, data generation, read compare and address sequencing.
    always_comb begin
        info_s      = elem_info(elem_r);
        run_s       = (state_r == ST_RUN);
        is_read_s   = info_s.two_op ? ~op_r : info_s.first_rd;
        exp_data_s  = bg_word(bg_r, addr_s[0], info_s.rd_pol);
        wr_data_s   = bg_word(bg_r, addr_s[0], info_s.wr_pol);
        mismatch_s  = run_s && is_read_s && (rf_rdata_a_i != exp_data_s);
        if (mismatch_s && (fail_cnt_r != CNT_MAX)) begin
            cnt_next_s = fail_cnt_r + CNT_WIDTH'(1);
        end else begin
            cnt_next_s = fail_cnt_r;
        end
        addr_done_s = ~info_s.two_op | op_r;
        elem_done_s = addr_done_s && last_s;
        test_end_s  = elem_done_s && (elem_r == ELEM_LAST) && ((bg_r == BG_CHECKER) || !CB_EN);
        next_elem_s = (elem_r == ELEM_LAST) ? 3'd0 : (elem_r + 3'd1);
        start_go_s  = !run_s && start_i && !abort_i;
        load_s      = start_go_s || (run_s && elem_done_s && !test_end_s);
        load_top_s  = start_go_s ? 1'b0 : elem_is_down(next_elem_s);
        step_s      = run_s && addr_done_s && !last_s;
    end

    // Control FSM with sequencing counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            bist_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_addr_r <= {ADDR_WIDTH{1'b0}};
            fail_elem_r <= 3'd0;
            fail_cnt_r  <= {CNT_WIDTH{1'b0}};
            elem_r      <= 3'd0;
            op_r        <= 1'b0;
            bg_r        <= BG_SOLID;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (abort_i) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                    end else if (start_i) begin
                        state_r     <= ST_RUN;
                        bist_r      <= 1'b1;
                        done_r      <= 1'b0;
                        pass_r      <= 1'b0;
                        fail_addr_r <= {ADDR_WIDTH{1'b0}};
                        fail_elem_r <= 3'd0;
                        fail_cnt_r  <= {CNT_WIDTH{1'b0}};
                        elem_r      <= 3'd0;
                        op_r        <= 1'b0;
                        bg_r        <= BG_SOLID;
                    end
                end
                ST_RUN: begin
                    fail_cnt_r <= cnt_next_s;
                    if (mismatch_s && (fail_cnt_r == {CNT_WIDTH{1'b0}})) begin
                        fail_addr_r <= addr_s;
                        fail_elem_r <= elem_r;
                    end
                    if (abort_i) begin
                        state_r <= ST_IDLE;
                        bist_r  <= 1'b0;
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                    end else if (test_end_s) begin
                        state_r <= ST_DONE;
                        bist_r  <= 1'b0;
                        done_r  <= 1'b1;
                        pass_r  <= (cnt_next_s == {CNT_WIDTH{1'b0}});
                    end else if (!addr_done_s) begin
                        op_r <= 1'b1;
                    end else begin
                        op_r <= 1'b0;
                        if (elem_done_s) begin
                            elem_r <= next_elem_s;
                            if (elem_r == ELEM_LAST) begin
                                bg_r <= BG_CHECKER;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    bist_r  <= 1'b0;
                    done_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    // Port multiplexer: engine owns port A and masks port B while running.
    always_comb begin
        if (bist_r) begin
            rf_raddr_a_o = addr_s;
            rf_waddr_a_o = addr_s;
            rf_wdata_a_o = wr_data_s;
            rf_we_a_o    = ~is_read_s;
            rf_waddr_b_o = {ADDR_WIDTH{1'b0}};
            rf_wdata_b_o = {DATA_WIDTH{1'b0}};
            rf_we_b_o    = 1'b0;
        end else begin
            rf_raddr_a_o = raddr_a_i;
            rf_waddr_a_o = waddr_a_i;
            rf_wdata_a_o = wdata_a_i;
            rf_we_a_o    = we_a_i;
            rf_waddr_b_o = waddr_b_i;
            rf_wdata_b_o = wdata_b_i;
            rf_we_b_o    = we_b_i;
        end
    end

    assign bist_o      = bist_r;
    assign done_o      = done_r;
    assign pass_o      = pass_r;
    assign fail_addr_o = fail_addr_r;
    assign fail_elem_o = fail_elem_r;
    assign fail_cnt_o  = fail_cnt_r;

endmodule
